// File: rtl/y86_pkg.sv
// Y86-64 constants shared by decode and the memory/writeback stage,
// plus the M and W pipeline register layouts.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] R_RAX = 4'h0;
   localparam logic [3:0] R_RCX = 4'h1;
   localparam logic [3:0] R_RDX = 4'h2;
   localparam logic [3:0] R_RBX = 4'h3;
   localparam logic [3:0] R_RSP = 4'h4;
   localparam logic [3:0] R_RBP = 4'h5;
   localparam logic [3:0] R_RSI = 4'h6;
   localparam logic [3:0] R_RDI = 4'h7;
   localparam logic [3:0] RNONE = 4'hF;

   typedef struct packed {
      logic [3:0]  icode;
      logic [2:0]  stat;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } m_reg_t;

   typedef struct packed {
      logic [3:0]  icode;
      logic [2:0]  stat;
      logic [63:0] valE;
      logic [63:0] valM;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } w_reg_t;

   localparam m_reg_t M_NOP = '{icode: I_NOP, stat: S_AOK, valE: 64'd0,
                                valA: 64'd0, dstE: RNONE, dstM: RNONE};
   localparam w_reg_t W_NOP = '{icode: I_NOP, stat: S_AOK, valE: 64'd0,
                                valM: 64'd0, dstE: RNONE, dstM: RNONE};

   function automatic logic mem_reads(input logic [3:0] icode);
      return icode inside {I_MRMOVQ, I_POPQ, I_RET};
   endfunction

   function automatic logic mem_writes(input logic [3:0] icode);
      return icode inside {I_RMMOVQ, I_PUSHQ, I_CALL};
   endfunction

   // popq/ret address through the old stack pointer carried in valA
   function automatic logic addr_from_valA(input logic [3:0] icode);
      return icode inside {I_POPQ, I_RET};
   endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed data memory: combinational little-endian 8-byte read,
// synchronous 8-byte write. Byte addresses wrap modulo DMEM_BYTES.
module data_memory #(
   parameter int DMEM_BYTES = 4096,
   parameter int ADDR_W     = 12
) (
   input  logic              clock,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [63:0]       wdata_i,
   output logic [63:0]       rdata_o
);

   // Zeroed at power-up only; reset deliberately leaves contents alone.
   logic [7:0] mem_q [DMEM_BYTES] = '{default: 8'h00};
   logic [7:0][ADDR_W-1:0] byte_addr;

   for (genvar b = 0; b < 8; b++) begin : g_byte
      assign byte_addr[b] = addr_i + ADDR_W'(b);
      assign rdata_o[8*b +: 8] = mem_q[byte_addr[b]];
   end

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         for (int b = 0; b < 8; b++) begin
            mem_q[byte_addr[b]] <= wdata_i[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/memory_writeback_stage.sv
// Y86-64 memory stage with M and W pipeline registers.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range accesses raise ADR instead of wrapping.
module memory_writeback_stage
   import y86_pkg::*;
#(
   parameter int DMEM_BYTES = 4096,
   parameter int ADDR_W     = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  E_icode,
   input  logic [2:0]  E_stat,
   input  logic [63:0] e_valE,
   input  logic [63:0] E_valA,
   input  logic [3:0]  E_dstE,
   input  logic [3:0]  E_dstM,
   input  logic        M_bubble,
   input  logic        W_stall,
   output logic [3:0]  M_icode,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM,
   output logic [63:0] M_valE,
   output logic [63:0] m_valM,
   output logic [2:0]  m_stat,
   output logic [3:0]  W_icode,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [2:0]  W_stat
);

   m_reg_t m_q, m_d;
   w_reg_t w_q, w_d;
   logic   wblk_q, wblk_d;

   logic [63:0] mem_addr;
   logic [63:0] rdata;
   logic        rd_en, wr_req, wr_en, oob;
   logic        unused_addr_hi;

   assign rd_en    = mem_reads(m_q.icode);
   assign wr_req   = mem_writes(m_q.icode);
   assign mem_addr = addr_from_valA(m_q.icode) ? m_q.valA : m_q.valE;
   assign unused_addr_hi = ^mem_addr[63:ADDR_W];

`ifdef MEM_BOUNDS_CHECK_EN
   // 65-bit sum so addresses near 2^64 cannot wrap back into range
   logic [64:0] last_byte;
   assign last_byte = {1'b0, mem_addr} + 65'd7;
   assign oob = (rd_en | wr_req) && (last_byte >= 65'(DMEM_BYTES));
`else
   assign oob = 1'b0;
`endif

   assign m_stat = oob ? S_ADR : m_q.stat;
   assign m_valM = (rd_en && !oob) ? rdata : 64'd0;

   // Once a fault has retired, no further stores may commit until reset.
   assign wr_en = wr_req && !oob && (m_stat == S_AOK) && (w_q.stat == S_AOK)
                  && !wblk_q && !reset;

   data_memory #(
      .DMEM_BYTES(DMEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_dmem (
      .clock  (clock),
      .wr_en_i(wr_en),
      .addr_i (mem_addr[ADDR_W-1:0]),
      .wdata_i(m_q.valA),
      .rdata_o(rdata)
   );

   always_comb begin
      m_d = m_q;
      w_d = w_q;
      if (M_bubble) begin
         m_d = M_NOP;
      end else begin
         m_d = '{icode: E_icode, stat: E_stat, valE: e_valE, valA: E_valA,
                 dstE: E_dstE, dstM: E_dstM};
      end
      if (!W_stall) begin
         w_d = '{icode: m_q.icode, stat: m_stat, valE: m_q.valE, valM: m_valM,
                 dstE: m_q.dstE, dstM: m_q.dstM};
      end
      wblk_d = wblk_q | (w_q.stat != S_AOK);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         m_q    <= M_NOP;
         w_q    <= W_NOP;
         wblk_q <= 1'b0;
      end else begin
         m_q    <= m_d;
         w_q    <= w_d;
         wblk_q <= wblk_d;
      end
   end

   assign M_icode = m_q.icode;
   assign M_dstE  = m_q.dstE;
   assign M_dstM  = m_q.dstM;
   assign M_valE  = m_q.valE;
   assign W_icode = w_q.icode;
   assign W_dstE  = w_q.dstE;
   assign W_dstM  = w_q.dstM;
   assign W_valE  = w_q.valE;
   assign W_valM  = w_q.valM;
   assign W_stat  = w_q.stat;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Bench for memory_writeback_stage: directed vector table, then random traffic
// compared every cycle against a byte-array reference model.
module tb_memory_writeback_stage;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BND = 1'b1;
`else
   localparam bit BND = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  E_icode;
   logic [2:0]  E_stat;
   logic [63:0] e_valE, E_valA;
   logic [3:0]  E_dstE, E_dstM;
   logic        M_bubble, W_stall;
   logic [3:0]  M_icode, M_dstE, M_dstM;
   logic [63:0] M_valE, m_valM;
   logic [2:0]  m_stat;
   logic [3:0]  W_icode, W_dstE, W_dstM;
   logic [63:0] W_valE, W_valM;
   logic [2:0]  W_stat;

   always #5 clock = ~clock;

   memory_writeback_stage dut (
      .clock(clock), .reset(reset), .E_icode(E_icode), .E_stat(E_stat),
      .e_valE(e_valE), .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .M_bubble(M_bubble), .W_stall(W_stall), .M_icode(M_icode),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
      .m_stat(m_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .W_valE(W_valE), .W_valM(W_valM), .W_stat(W_stat)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  ic;
      logic [2:0]  st;
      logic [63:0] ve, va;
      logic [3:0]  de, dm;
      logic        bub, stall;
      logic        chk;
      logic [3:0]  x_wic, x_mic, x_wdm;
      logic [63:0] x_wve, x_wvm, x_mvm;
      logic [2:0]  x_ws, x_ms;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  rmem [4096];
   logic [3:0]  mi, mde, mdm, wi, wde, wdm;
   logic [2:0]  ms, ws;
   logic [63:0] mve, mva, wve, wvm;
   bit          blocked, started;

   function automatic logic [63:0] r_addr();
      return (mi == 4'h9 || mi == 4'hB) ? mva : mve;
   endfunction
   function automatic bit r_rd();
      return mi == 4'h5 || mi == 4'h9 || mi == 4'hB;
   endfunction
   function automatic bit r_wr();
      return mi == 4'h4 || mi == 4'h8 || mi == 4'hA;
   endfunction
   function automatic bit r_oob();
      logic [64:0] last;
      last = {1'b0, r_addr()} + 65'd7;
      return BND && (r_rd() || r_wr()) && (last >= 65'd4096);
   endfunction
   function automatic logic [2:0] r_mstat();
      return r_oob() ? 3'd3 : ms;
   endfunction
   function automatic int r_idx(input int i);
      return int'((r_addr() + 64'(i)) % 64'd4096);
   endfunction
   function automatic logic [63:0] r_valM();
      logic [63:0] v = 64'd0;
      if (r_rd() && !r_oob())
         for (int i = 0; i < 8; i++) v[8*i +: 8] = rmem[r_idx(i)];
      return v;
   endfunction

   task automatic model_reset();
      mi = 4'h1; ms = 3'd1; mve = 0; mva = 0; mde = 4'hF; mdm = 4'hF;
      wi = 4'h1; ws = 3'd1; wve = 0; wvm = 0; wde = 4'hF; wdm = 4'hF;
      blocked = 0;
   endtask

   task automatic model_step();
      logic [2:0]  cur_ms;
      logic [63:0] cur_vm;
      if (reset) begin
         model_reset();
      end else begin
         cur_ms = r_mstat();
         cur_vm = r_valM();
         if (r_wr() && cur_ms == 3'd1 && ws == 3'd1 && !blocked)
            for (int i = 0; i < 8; i++) rmem[r_idx(i)] = mva[8*i +: 8];
         if (ws != 3'd1) blocked = 1;
         if (!W_stall) begin
            wi = mi; ws = cur_ms; wve = mve; wvm = cur_vm; wde = mde; wdm = mdm;
         end
         if (M_bubble) begin
            mi = 4'h1; ms = 3'd1; mve = 0; mva = 0; mde = 4'hF; mdm = 4'hF;
         end else begin
            mi = E_icode; ms = E_stat; mve = e_valE; mva = E_valA;
            mde = E_dstE; mdm = E_dstM;
         end
      end
      started = 1;
   endtask

   task automatic model_check();
      chk("M_icode", M_icode, mi);
      chk("M_dstE",  M_dstE,  mde);
      chk("M_dstM",  M_dstM,  mdm);
      chk("M_valE",  M_valE,  mve);
      chk("m_valM",  m_valM,  r_valM());
      chk("m_stat",  m_stat,  r_mstat());
      chk("W_icode", W_icode, wi);
      chk("W_dstE",  W_dstE,  wde);
      chk("W_dstM",  W_dstM,  wdm);
      chk("W_valE",  W_valE,  wve);
      chk("W_valM",  W_valM,  wvm);
      chk("W_stat",  W_stat,  ws);
   endtask

   // ---------------- vector helpers ----------------
   function automatic vec_t iv(input logic rst, input logic [3:0] ic, input logic [63:0] ve,
                               input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                               input logic bub, input logic stall);
      vec_t v;
      v.rst = rst; v.ic = ic; v.st = 3'd1; v.ve = ve; v.va = va; v.de = de; v.dm = dm;
      v.bub = bub; v.stall = stall; v.chk = 0;
      v.x_wic = 0; v.x_mic = 0; v.x_wdm = 0; v.x_wve = 0; v.x_wvm = 0; v.x_mvm = 0;
      v.x_ws = 0; v.x_ms = 0;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic [3:0] wic, input logic [3:0] mic,
                               input logic [3:0] wdm_x, input logic [63:0] wve_x,
                               input logic [63:0] wvm_x, input logic [63:0] mvm,
                               input logic [2:0] ws_x, input logic [2:0] ms_x);
      vec_t v = vi;
      v.chk = 1; v.x_wic = wic; v.x_mic = mic; v.x_wdm = wdm_x; v.x_wve = wve_x;
      v.x_wvm = wvm_x; v.x_mvm = mvm; v.x_ws = ws_x; v.x_ms = ms_x;
      return v;
   endfunction

   task automatic run_cycle(input vec_t v, input int idx);
      reset = v.rst; E_icode = v.ic; E_stat = v.st; e_valE = v.ve; E_valA = v.va;
      E_dstE = v.de; E_dstM = v.dm; M_bubble = v.bub; W_stall = v.stall;
      @(negedge clock);
      if (started) model_check();
      if (v.chk) begin
         chk($sformatf("tbl%0d_W_icode", idx), W_icode, v.x_wic);
         chk($sformatf("tbl%0d_M_icode", idx), M_icode, v.x_mic);
         chk($sformatf("tbl%0d_W_dstM", idx),  W_dstM,  v.x_wdm);
         chk($sformatf("tbl%0d_W_valE", idx),  W_valE,  v.x_wve);
         chk($sformatf("tbl%0d_W_valM", idx),  W_valM,  v.x_wvm);
         chk($sformatf("tbl%0d_m_valM", idx),  m_valM,  v.x_mvm);
         chk($sformatf("tbl%0d_W_stat", idx),  W_stat,  v.x_ws);
         chk($sformatf("tbl%0d_m_stat", idx),  m_stat,  v.x_ms);
      end
      @(posedge clock);
      model_step();
      #1;
   endtask

   function automatic logic [63:0] rand_addr();
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: return 64'($urandom_range(0, 7) * 8);
         6, 7:             return 64'h0FF8 + 64'($urandom_range(0, 7));
         8:                return 64'($urandom_range(0, 4095));
         default:          return {$urandom, $urandom};
      endcase
   endfunction

   localparam logic [63:0] D1 = 64'h1122334455667788;
   localparam logic [63:0] D2 = 64'h0102030405060708;
   localparam logic [3:0]  F  = 4'hF;

   vec_t vq[$];

   initial begin
      vec_t v;
      logic [63:0] rst_w = 64'd0;
      for (int i = 0; i < 4096; i++) rmem[i] = 8'h00;
      model_reset();
      started = 0;

      // c0..c2 reset and idle
      vq.push_back(iv(1, 4'h1, 0, 0, F, F, 0, 0));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 1, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 1, F, 0, 0, 0, 1, 1));
      // c3..c6 store then load at 0x100
      vq.push_back(ex(iv(0, 4'h4, 64'h100, D1, F, F, 0, 0), 1, 1, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'h100, 0, F, 3, 0, 0), 1, 4, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 4, 5, F, 64'h100, 0, D1, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 5, 1, 3, 64'h100, D1, 0, 1, 1));
      // c7..c10 push/pop round trip
      vq.push_back(iv(0, 4'hA, 64'hF8, 64'hABCD, 4, F, 0, 0));
      vq.push_back(ex(iv(0, 4'hB, 64'h100, 64'hF8, 4, 0, 0, 0), 1, 4'hA, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 4'hA, 4'hB, F, 64'hF8, 0, 64'hABCD, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 4'hB, 1, 0, 64'h100, 64'hABCD, 0, 1, 1));
      // c11..c13 bubbled store leaves 0x200 untouched
      vq.push_back(ex(iv(0, 4'h4, 64'h200, 64'hDEAD, F, F, 1, 0), 1, 1, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'h200, 0, F, 5, 0, 0), 1, 1, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 5, F, 0, 0, 0, 1, 1));
      // c14..c19 W stall for three edges, bubble+stall together on the last
      vq.push_back(ex(iv(0, 4'h5, 64'h100, 0, F, 7, 0, 0), 5, 1, 5, 64'h200, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 5, F, 0, 0, D1, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 1), 5, 1, 7, 64'h100, D1, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 1), 5, 1, 7, 64'h100, D1, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h4, 64'h300, 64'h55, F, F, 1, 1), 5, 1, 7, 64'h100, D1, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'h300, 0, F, 6, 0, 0), 5, 1, 7, 64'h100, D1, 0, 1, 1));
      // c20..c24 reset while a call sits in M
      vq.push_back(ex(iv(0, 4'h8, 64'h400, 64'h77, 4, F, 0, 0), 1, 5, F, 0, 0, 0, 1, 1));
      vq.push_back(iv(1, 4'h1, 0, 0, F, F, 0, 0));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 1, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'h400, 0, F, 2, 0, 0), 1, 1, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 5, F, 0, 0, 0, 1, 1));
      // c25..c32 store straddling the top of memory, then a later store
      vq.push_back(ex(iv(0, 4'h4, 64'hFFC, D2, F, F, 0, 0), 5, 1, 2, 64'h400, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 1, 4, F, 0, 0, 0, 1, BND ? 3 : 1));
      vq.push_back(ex(iv(0, 4'h4, 64'h500, 64'h99, F, F, 0, 0), 4, 1, F, 64'hFFC, 0, 0,
                      BND ? 3 : 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'h500, 0, F, 1, 0, 0), 1, 4, F, 0, 0, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 4, 5, F, 64'h500, 0,
                      BND ? 64'h0 : 64'h99, 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'hFFC, 0, F, 1, 0, 0), 5, 1, 1, 64'h500,
                      BND ? 64'h0 : 64'h99, 0, 1, 1));
      vq.push_back(ex(iv(0, 4'h5, 64'h0, 0, F, 1, 0, 0), 1, 5, F, 0, 0,
                      BND ? 64'h0 : D2, 1, BND ? 3 : 1));
      vq.push_back(ex(iv(0, 4'h1, 0, 0, F, F, 0, 0), 5, 5, 1, 64'hFFC,
                      BND ? 64'h0 : D2, BND ? 64'h0 : 64'h01020304, BND ? 3 : 1, 1));

      for (int i = 0; i < vq.size(); i++) run_cycle(vq[i], i);

      // random traffic, model-checked every cycle
      run_cycle(iv(1, 4'h1, 0, 0, F, F, 0, 0), -1);
      for (int n = 0; n < 600; n++) begin
         v = iv(($urandom_range(0, 99) < 2), 4'h1, 0, 0, F, F, 0, 0);
         if ($urandom_range(0, 9) < 6) begin
            case ($urandom_range(0, 5))
               0: v.ic = 4'h4; 1: v.ic = 4'h5; 2: v.ic = 4'h8;
               3: v.ic = 4'h9; 4: v.ic = 4'hA; default: v.ic = 4'hB;
            endcase
         end else begin
            v.ic = 4'($urandom_range(0, 15));
         end
         v.st    = ($urandom_range(0, 59) == 0) ? 3'd2 : 3'd1;
         v.ve    = rand_addr();
         v.va    = $urandom_range(0, 1) ? rand_addr() : {$urandom, $urandom};
         v.de    = 4'($urandom_range(0, 15));
         v.dm    = 4'($urandom_range(0, 15));
         v.bub   = ($urandom_range(0, 9) == 0);
         v.stall = ($urandom_range(0, 9) == 0);
         rst_w   = rst_w + 64'(v.rst);
         run_cycle(v, 1000 + n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
